// File: rtl/ads8588h_par_reader.sv
// ADS8588H parallel-mode controller: ADC reset pulse, periodic CONVST, busy handshake,
// CS/RD word reads and per-channel sample delivery with sticky error flags.
module ads8588h_par_reader #(
  parameter int CONV_PERIOD  = 100,
  parameter int NUM_CH       = 8,
  parameter int RST_CYCLES   = 8,
  parameter int CONVST_W     = 2,
  parameter int RD_LOW       = 2,
  parameter int RD_HIGH      = 2,
  parameter int BUSY_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        adc_reset,
  output logic        convst,
  input  logic        busy,
  output logic        cs,
  output logic        rd,
  input  logic [15:0] db,
  output logic        sample_valid,
  output logic [2:0]  sample_ch,
  output logic [15:0] sample_data,
  output logic        frame_done,
  output logic        timeout_err,
  output logic        overrun_err,
  input  logic        err_clr,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ADC_RST, IDLE, CONVST, WAIT_HI, WAIT_LO, RD_L, RD_H, DONE
  } state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX = max_of(max_of(RST_CYCLES, BUSY_TIMEOUT),
                               max_of(CONVST_W, max_of(RD_LOW, RD_HIGH)));
  localparam int TW = $clog2(TMAX + 1);
  localparam int PW = (CONV_PERIOD > 1) ? $clog2(CONV_PERIOD) : 1;

  localparam logic [TW-1:0] T_RST    = TW'(RST_CYCLES);
  localparam logic [TW-1:0] T_CONVST = TW'(CONVST_W - 1);
  localparam logic [TW-1:0] T_RDL    = TW'(RD_LOW - 1);
  localparam logic [TW-1:0] T_RDH    = TW'(RD_HIGH - 1);
  localparam logic [TW-1:0] T_BUSY   = TW'(BUSY_TIMEOUT - 1);
  localparam logic [PW-1:0] P_LAST   = PW'(CONV_PERIOD - 1);
  localparam logic [2:0]    LAST_CH  = 3'(NUM_CH - 1);

  state_t        state, state_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [2:0]    ch, ch_nx;
  logic [PW-1:0] pcnt;
  logic          busy_s1, busy_s2;
  logic          trigger, capture, set_timeout, set_overrun;

  assign trigger     = (pcnt == '0) && enable;
  assign set_overrun = trigger && (state != IDLE) && (state != ADC_RST);
  assign dbg_state   = state;

  always_comb begin
    state_nx    = state;
    tcnt_nx     = tcnt + TW'(1);
    ch_nx       = ch;
    capture     = 1'b0;
    set_timeout = 1'b0;
    case (state)
      // The first cycle after reset release is spent here with adc_reset still low,
      // so the exit count is RST_CYCLES rather than RST_CYCLES-1.
      ADC_RST: if (tcnt == T_RST) state_nx = IDLE;
      IDLE:    if (trigger) state_nx = CONVST;
      CONVST:  if (tcnt == T_CONVST) state_nx = WAIT_HI;
      WAIT_HI: begin
        if (busy_s2) state_nx = WAIT_LO;
        else if (tcnt == T_BUSY) begin
          set_timeout = 1'b1;
          state_nx    = IDLE;
        end
      end
      WAIT_LO: begin
        if (!busy_s2) begin
          ch_nx    = 3'd0;
          state_nx = RD_L;
        end else if (tcnt == T_BUSY) begin
          set_timeout = 1'b1;
          state_nx    = IDLE;
        end
      end
      RD_L: if (tcnt == T_RDL) begin
        capture  = 1'b1;
        state_nx = RD_H;
      end
      RD_H: if (tcnt == T_RDH) begin
        if (ch == LAST_CH) state_nx = DONE;
        else begin
          ch_nx    = ch + 3'd1;
          state_nx = RD_L;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = ADC_RST;
    endcase
    if (state_nx != state) tcnt_nx = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ADC_RST;
      tcnt    <= '0;
      ch      <= '0;
      pcnt    <= '0;
      busy_s1 <= 1'b0;
      busy_s2 <= 1'b0;
    end else begin
      state   <= state_nx;
      tcnt    <= tcnt_nx;
      ch      <= ch_nx;
      busy_s1 <= busy;
      busy_s2 <= busy_s1;
      if (!enable || pcnt == P_LAST) pcnt <= '0;
      else pcnt <= pcnt + PW'(1);
    end
  end

  // Strobes are registered from the next state so they line up with the state register
  // and return to their idle levels the instant reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adc_reset    <= 1'b0;
      convst       <= 1'b0;
      cs           <= 1'b1;
      rd           <= 1'b1;
      frame_done   <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      adc_reset    <= (state_nx == ADC_RST);
      convst       <= (state_nx == CONVST);
      cs           <= !((state_nx == RD_L) || (state_nx == RD_H));
      rd           <= (state_nx != RD_L);
      frame_done   <= (state_nx == DONE);
      sample_valid <= capture;
      if (capture) begin
        sample_ch   <= ch;
        sample_data <= db;
      end
      if (set_timeout) timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
      if (set_overrun) overrun_err <= 1'b1;
      else if (err_clr) overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ads8588h_par_reader.sv
// Directed bench for ads8588h_par_reader: a default-parameter instance with busy/db ADC models,
// plus a short-period instance for the overrun case.
module tb_ads8588h_par_reader;

  localparam logic [2:0] S_ADC_RST = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // main instance signals
  logic        enable, err_clr, busy;
  logic [15:0] db = '0;
  logic        adc_reset, convst, cs, rd, sample_valid, frame_done, timeout_err, overrun_err;
  logic [2:0]  sample_ch, dbg_state;
  logic [15:0] sample_data;

  // overrun instance signals
  logic        enable2, busy2;
  logic [15:0] db2;
  logic        adc_reset2, convst2, cs2, rd2, sample_valid2, frame_done2, timeout_err2, overrun_err2;
  logic [2:0]  sample_ch2, dbg_state2;
  logic [15:0] sample_data2;

  ads8588h_par_reader u_dut (
    .clk(clk), .reset(reset), .enable(enable), .adc_reset(adc_reset), .convst(convst),
    .busy(busy), .cs(cs), .rd(rd), .db(db), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample_data(sample_data), .frame_done(frame_done),
    .timeout_err(timeout_err), .overrun_err(overrun_err), .err_clr(err_clr),
    .dbg_state(dbg_state)
  );

  ads8588h_par_reader #(.CONV_PERIOD(64), .BUSY_TIMEOUT(128)) u_ovr (
    .clk(clk), .reset(reset), .enable(enable2), .adc_reset(adc_reset2), .convst(convst2),
    .busy(busy2), .cs(cs2), .rd(rd2), .db(db2), .sample_valid(sample_valid2),
    .sample_ch(sample_ch2), .sample_data(sample_data2), .frame_done(frame_done2),
    .timeout_err(timeout_err2), .overrun_err(overrun_err2), .err_clr(err_clr),
    .dbg_state(dbg_state2)
  );

  // scoreboard
  typedef struct {
    logic [2:0]  ch;
    logic [15:0] data;
  } samp_t;

  samp_t       exp_tab [8];
  samp_t       got_q[$];
  samp_t       got2_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_conv = 0;
  int          prev_conv = 0;
  int          cs_low_cnt = 0;
  logic        conv_d = 1'b0;
  logic [15:0] db_base = 16'h1000;
  bit          busy_en = 1'b1;
  int          busy_hi = 12;
  int          rd_idx = 0;

  // ADC busy model: rises two cycles after convst, stays high busy_hi cycles
  initial begin
    busy = 1'b0;
    forever begin
      @(posedge convst);
      if (busy_en) begin
        repeat (2) @(posedge clk);
        #1 busy = 1'b1;
        repeat (busy_hi) @(posedge clk);
        #1 busy = 1'b0;
      end
    end
  end

  // ADC data model: each RD fall presents the next channel word; cs high restarts at channel 0
  always @(negedge rd or posedge cs) begin
    if (cs) rd_idx = 0;
    else begin
      db = db_base + 16'(rd_idx);
      rd_idx++;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (sample_valid) got_q.push_back('{ch: sample_ch, data: sample_data});
    if (sample_valid2) got2_q.push_back('{ch: sample_ch2, data: sample_data2});
    if (convst && !conv_d) begin
      prev_conv = last_conv;
      last_conv = cyc;
    end
    conv_d = convst;
    if (!cs) cs_low_cnt++;
  end

  // driver / checker tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_table(input logic [15:0] base);
    db_base = base;
    for (int k = 0; k < 8; k++) begin
      exp_tab[k].ch   = 3'(k);
      exp_tab[k].data = base + 16'(k);
    end
  endtask

  task automatic check_frame(input string tag);
    check({tag, " words"}, 32'(got_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      check($sformatf("%s word%0d ch", tag, k), 32'(got_q[k].ch), 32'(exp_tab[k].ch));
      check($sformatf("%s word%0d data", tag, k), 32'(got_q[k].data), 32'(exp_tab[k].data));
    end
    got_q.delete();
  endtask

  task automatic wait_fd(input string tag, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (frame_done) seen = 1'b1;
    end
    check({tag, " frame_done seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_sample_ch(input string tag, input logic [2:0] c, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (sample_valid && sample_ch == c) seen = 1'b1;
    end
    check({tag, " sample seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_convst(input string tag, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (convst) seen = 1'b1;
    end
    check({tag, " convst seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_adc_reset_pulse(input string tag);
    int hi = 0;
    int cv = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (adc_reset) hi++;
      if (convst) cv++;
    end
    check({tag, " adc_reset width"}, 32'(hi), 32'd8);
    check({tag, " convst during adc reset"}, 32'(cv), 32'd0);
    check({tag, " state idle"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int to_at;
    int cv;
    reset = 1'b0; enable = 1'b0; err_clr = 1'b0;
    enable2 = 1'b0; busy2 = 1'b0; db2 = 16'hBEEF;
    fill_table(16'h1000);

    // 1. reset values, ADC reset pulse, first convst
    repeat (3) tick();
    check("rst adc_reset", 32'(adc_reset), 32'd0);
    check("rst convst", 32'(convst), 32'd0);
    check("rst cs", 32'(cs), 32'd1);
    check("rst rd", 32'(rd), 32'd1);
    check("rst sample_valid", 32'(sample_valid), 32'd0);
    check("rst sample_ch", 32'(sample_ch), 32'd0);
    check("rst sample_data", 32'(sample_data), 32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);
    check("rst timeout_err", 32'(timeout_err), 32'd0);
    check("rst overrun_err", 32'(overrun_err), 32'd0);
    check("rst state", 32'(dbg_state), 32'(S_ADC_RST));
    reset = 1'b1;
    check_adc_reset_pulse("power-up");

    // 2. normal frame: latency, words, cs window, period
    cs_low_cnt = 0;
    enable = 1'b1;
    tick();
    check("first convst", 32'(convst), 32'd1);
    lat = 0;
    for (int i = 1; i <= 60 && lat == 0; i++) begin
      tick();
      if (sample_valid) lat = i;
    end
    check("first sample latency", 32'(lat), 32'd19);
    wait_fd("frame1", 100);
    check("cs low cycles", 32'(cs_low_cnt), 32'd32);
    check("frame1 cs high at done", 32'(cs), 32'd1);
    check_frame("frame1");
    tick();
    check("frame_done one cycle", 32'(frame_done), 32'd0);
    check("frame1 no overrun", 32'(overrun_err), 32'd0);

    // 3. busy never rises -> timeout, clear, then a normal frame
    busy_en = 1'b0;
    wait_convst("frame2", 120);
    check("convst period", 32'(last_conv - prev_conv), 32'd100);
    to_at = 0;
    for (int i = 1; i <= 40 && to_at == 0; i++) begin
      tick();
      if (timeout_err) to_at = i;
    end
    check("timeout cycle", 32'(to_at), 32'd34);
    check("timeout no samples", 32'(got_q.size()), 32'd0);
    check("timeout back to idle", 32'(dbg_state), 32'(S_IDLE));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr timeout", 32'(timeout_err), 32'd0);
    busy_en = 1'b1;
    fill_table(16'h2000);
    wait_fd("frame3", 200);
    check_frame("frame3");

    // 6. enable dropped at ch2: frame still completes, no further convst
    fill_table(16'h3000);
    wait_sample_ch("frame4 ch2", 3'd2, 200);
    enable = 1'b0;
    wait_fd("frame4", 60);
    check_frame("frame4");
    cv = 0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (convst) cv++;
    end
    check("no convst after disable", 32'(cv), 32'd0);

    // 5. reset mid-read at ch3, ADC reset re-run, next frame restarts at ch0
    fill_table(16'h4000);
    enable = 1'b1;
    wait_sample_ch("frame5 ch2", 3'd2, 100);
    tick();
    tick();
    check("pre-reset cs low", 32'(cs), 32'd0);
    check("pre-reset rd low", 32'(rd), 32'd0);
    reset = 1'b0;
    #1;
    check("async reset cs", 32'(cs), 32'd1);
    check("async reset rd", 32'(rd), 32'd1);
    check("async reset sample_valid", 32'(sample_valid), 32'd0);
    got_q.delete();
    repeat (2) tick();
    reset = 1'b1;
    check_adc_reset_pulse("rerun");
    wait_fd("frame6", 200);
    check_frame("frame6");
    check("no overrun after rerun", 32'(overrun_err), 32'd0);
    enable = 1'b0;

    // 4. 64-cycle period with busy held 60 cycles -> overrun, frame still completes
    enable2 = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        tick();
        if (convst2) seen = 1'b1;
      end
      check("ovr convst seen", 32'(seen), 32'd1);
    end
    repeat (2) @(posedge clk);
    #1 busy2 = 1'b1;
    repeat (60) @(posedge clk);
    #1 busy2 = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        tick();
        if (frame_done2) seen = 1'b1;
      end
      check("ovr frame_done seen", 32'(seen), 32'd1);
    end
    enable2 = 1'b0;
    check("ovr overrun_err", 32'(overrun_err2), 32'd1);
    check("ovr timeout_err", 32'(timeout_err2), 32'd0);
    check("ovr words", 32'(got2_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < got2_q.size(); k++) begin
      check($sformatf("ovr word%0d ch", k), 32'(got2_q[k].ch), k);
      check($sformatf("ovr word%0d data", k), 32'(got2_q[k].data), 32'h0000BEEF);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr overrun", 32'(overrun_err2), 32'd0);
    check("main overrun still clear", 32'(overrun_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
